// File: rtl/layer_sequencer.sv
// Per-layer neuron/input walker: RAM read addressing, MAC qualifiers, output writes; LAYER_SEQ_BIAS_EN adds one bias read per neuron.
// Latency: N_NEURONS*(N_INPUTS+RAM_LAT+2) cycles from accepted start to done (+1 per neuron with bias); no backpressure, start ignored while busy.
module layer_sequencer #(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 2,
    parameter int N_LAYERS  = 3,
    parameter int RAM_LAT   = 1,
    parameter int WADDR_W   = 8,
    parameter int IADDR_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         layer,
    output logic [WADDR_W-1:0] weight_addr,
    output logic [IADDR_W-1:0] input_addr,
    output logic               mac_clr,
    output logic               mac_en,
    output logic               out_we,
    output logic [IADDR_W-1:0] out_addr,
    output logic               busy,
    output logic               done,
    output logic               layer_err
`ifdef LAYER_SEQ_BIAS_EN
    ,
    output logic               bias_sel
`endif
);

    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    localparam logic [WADDR_W-1:0] LAYER_STRIDE = WADDR_W'(N_NEURONS * N_INPUTS);
    localparam logic [WADDR_W-1:0] NEURON_STRIDE = WADDR_W'(N_INPUTS);
`ifdef LAYER_SEQ_BIAS_EN
    // Bias words sit after every layer's weight block.
    localparam logic [WADDR_W-1:0] BIAS_BASE = WADDR_W'(N_LAYERS * N_NEURONS * N_INPUTS);
    localparam logic [WADDR_W-1:0] BIAS_STRIDE = WADDR_W'(N_NEURONS);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
`ifdef LAYER_SEQ_BIAS_EN
        S_BIAS,
`endif
        S_ACC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]         layer_q, layer_d;
    logic               err_q, err_d;
    logic [NW-1:0]      n_q, n_d;
    logic [IW-1:0]      i_q, i_d;
    logic [1:0]         dcnt_q, dcnt_d;
    logic [WADDR_W-1:0] wa_q, wa_d;
    logic [IADDR_W-1:0] ia_q, ia_d;
    logic [IADDR_W-1:0] oa_q, oa_d;
    logic               issue;
    logic [RAM_LAT-1:0] iss_q;
`ifdef LAYER_SEQ_BIAS_EN
    logic               bias_issue;
    logic [RAM_LAT-1:0] bias_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            err_q   <= 1'b0;
            n_q     <= '0;
            i_q     <= '0;
            dcnt_q  <= '0;
            wa_q    <= '0;
            ia_q    <= '0;
            oa_q    <= '0;
            iss_q   <= '0;
`ifdef LAYER_SEQ_BIAS_EN
            bias_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            err_q   <= err_d;
            n_q     <= n_d;
            i_q     <= i_d;
            dcnt_q  <= dcnt_d;
            wa_q    <= wa_d;
            ia_q    <= ia_d;
            oa_q    <= oa_d;
            // Read strobes ride a RAM_LAT-deep line so mac_en meets the returning data.
            iss_q[0] <= issue;
            for (int k = 1; k < RAM_LAT; k++) begin
                iss_q[k] <= iss_q[k-1];
            end
`ifdef LAYER_SEQ_BIAS_EN
            bias_q[0] <= bias_issue;
            for (int k = 1; k < RAM_LAT; k++) begin
                bias_q[k] <= bias_q[k-1];
            end
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        err_d      = err_q;
        n_d        = n_q;
        i_d        = i_q;
        dcnt_d     = dcnt_q;
        wa_d       = wa_q;
        ia_d       = ia_q;
        oa_d       = oa_q;
        issue      = 1'b0;
`ifdef LAYER_SEQ_BIAS_EN
        bias_issue = 1'b0;
`endif
        mac_clr    = 1'b0;
        out_we     = 1'b0;
        done       = 1'b0;
        layer_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    layer_d = layer;
                    err_d   = ({30'd0, layer} >= N_LAYERS);
                    n_d     = '0;
                    state_d = ({30'd0, layer} >= N_LAYERS) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                mac_clr = 1'b1;
                i_d     = '0;
`ifdef LAYER_SEQ_BIAS_EN
                state_d = S_BIAS;
`else
                state_d = S_ACC;
`endif
            end
`ifdef LAYER_SEQ_BIAS_EN
            S_BIAS: begin
                issue      = 1'b1;
                bias_issue = 1'b1;
                wa_d       = BIAS_BASE + WADDR_W'(layer_q) * BIAS_STRIDE + WADDR_W'(n_q);
                state_d    = S_ACC;
            end
`endif
            S_ACC: begin
                issue = 1'b1;
                wa_d  = WADDR_W'(layer_q) * LAYER_STRIDE + WADDR_W'(n_q) * NEURON_STRIDE
                      + WADDR_W'(i_q);
                ia_d  = IADDR_W'(i_q);
                if (i_q == IW'(N_INPUTS - 1)) begin
                    dcnt_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == 2'(RAM_LAT - 1)) begin
                    state_d = S_WRITE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                out_we = 1'b1;
                oa_d   = IADDR_W'(n_q);
                if (n_q == NW'(N_NEURONS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                layer_err = err_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Addresses show the current issue while reading and hold the last one otherwise.
    assign weight_addr = wa_d;
    assign input_addr  = ia_d;
    assign out_addr    = oa_d;
    assign mac_en      = iss_q[RAM_LAT-1];
    assign busy        = (state_q != S_IDLE);
`ifdef LAYER_SEQ_BIAS_EN
    assign bias_sel    = bias_q[RAM_LAT-1];
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized and directed bench for layer_sequencer against a cycle-offset schedule model.
module tb_layer_sequencer;

    localparam int NI = 4;
    localparam int NN = 2;
    localparam int NL = 3;
    localparam int RL = 1;
    localparam int WW = 8;
    localparam int IW = 4;
`ifdef LAYER_SEQ_BIAS_EN
    localparam int BX = 1;
`else
    localparam int BX = 0;
`endif
    localparam int P = NI + RL + 2 + BX;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    layer;
    logic [WW-1:0] weight_addr;
    logic [IW-1:0] input_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          out_we;
    logic [IW-1:0] out_addr;
    logic          busy;
    logic          done;
    logic          layer_err;
    logic          bias_o;

    always #5 clk = ~clk;

    layer_sequencer #(
        .N_INPUTS (NI),
        .N_NEURONS(NN),
        .N_LAYERS (NL),
        .RAM_LAT  (RL),
        .WADDR_W  (WW),
        .IADDR_W  (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .layer      (layer),
        .weight_addr(weight_addr),
        .input_addr (input_addr),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .out_we     (out_we),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done),
`ifdef LAYER_SEQ_BIAS_EN
        .layer_err  (layer_err),
        .bias_sel   (bias_o)
`else
        .layer_err  (layer_err)
`endif
    );

`ifndef LAYER_SEQ_BIAS_EN
    assign bias_o = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a job is (accept edge, layer); every output is a function of cycles since accept.
    bit            m_act = 1'b0;
    bit            m_err = 1'b0;
    int            m_k = 0;
    int            m_L = 0;
    logic [WW-1:0] hw = '0;
    logic [IW-1:0] hi = '0;
    logic [IW-1:0] ho = '0;
    bit            e_clr, e_en, e_we, e_done, e_err, e_bias;
    int            en_cnt = 0;
    int            done_cnt = 0;

    task automatic tick();
        int n;
        int j;
        @(posedge clk);
        if (reset) begin
            m_act = 1'b0;
            hw = '0;
            hi = '0;
            ho = '0;
        end else if (m_act) begin
            if (m_k == (m_err ? 0 : NN * P)) m_act = 1'b0;
            else m_k++;
        end else if (start) begin
            m_act = 1'b1;
            m_k = 0;
            m_L = int'(layer);
            m_err = (m_L >= NL);
        end
        e_clr = 0; e_en = 0; e_we = 0; e_done = 0; e_err = 0; e_bias = 0;
        if (m_act) begin
            if (m_err) begin
                e_done = 1;
                e_err = 1;
            end else if (m_k == NN * P) begin
                e_done = 1;
            end else begin
                n = m_k / P;
                j = m_k % P;
                e_clr = (j == 0);
                e_we = (j == P - 1);
                if (e_we) ho = IW'(n);
                if (BX == 1 && j == 1) hw = WW'(NL * NN * NI + m_L * NN + n);
                if (j >= 1 + BX && j <= NI + BX) begin
                    hw = WW'(m_L * NN * NI + n * NI + (j - 1 - BX));
                    hi = IW'(j - 1 - BX);
                end
                e_en = (j >= 1 + RL) && (j <= NI + BX + RL);
                e_bias = (BX == 1) && (j == 1 + RL);
            end
        end
        @(negedge clk);
        check("ctl{busy,done,err,clr,en,we,bias}",
              32'({busy, done, layer_err, mac_clr, mac_en, out_we, bias_o}),
              32'({m_act, e_done, e_err, e_clr, e_en, e_we, e_bias}));
        check("weight_addr", 32'(weight_addr), 32'(hw));
        check("input_addr", 32'(input_addr), 32'(hi));
        check("out_addr", 32'(out_addr), 32'(ho));
        check("clr_en_overlap", 32'(mac_clr & mac_en), 32'd0);
        if (reset || mac_clr) en_cnt = 0;
        if (mac_en) en_cnt++;
        if (out_we) begin
            check("en_per_neuron", 32'(en_cnt), 32'(NI + BX));
            en_cnt = 0;
        end
        if (done) done_cnt++;
    endtask

    task automatic run_layer(input int L, output int lat, output logic err);
        start = 1'b1;
        layer = 2'(L);
        tick();
        start = 1'b0;
        lat = -1;
        err = 1'b0;
        for (int c = 0; c < 200 && lat < 0; c++) begin
            if (done) begin
                lat = c;
                err = layer_err;
            end else begin
                tick();
            end
        end
        tick();
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        logic err;
        int d0;
        reset = 1'b1;
        start = 1'b0;
        layer = 2'd0;
        repeat (5) tick();
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        for (int L = 0; L < 4; L++) begin
            run_layer((L + 1) % 4, lat, err);
            check("done_latency", 32'(lat), ((L + 1) % 4 >= NL) ? 32'd0 : 32'(NN * P));
            check("layer_err", 32'(err), ((L + 1) % 4 >= NL) ? 32'd1 : 32'd0);
        end

        // Second start during neuron 0 accumulation must be ignored.
        d0 = done_cnt;
        start = 1'b1;
        layer = 2'd1;
        tick();
        layer = 2'd2;
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (NN * P + 4) tick();
        check("one_done_busy_start", 32'(done_cnt - d0), 32'd1);

        // start held: second job begins on the first IDLE cycle.
        d0 = done_cnt;
        start = 1'b1;
        layer = 2'd0;
        repeat (2 * NN * P + 3) tick();
        start = 1'b0;
        check("held_start_dones", 32'(done_cnt - d0), 32'd2);
        repeat (4) tick();

        // Reset during the second input read of neuron 1.
        d0 = done_cnt;
        start = 1'b1;
        layer = 2'd0;
        tick();
        start = 1'b0;
        repeat (P + 2 + BX) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_weight_addr", 32'(weight_addr), 32'd0);
        tick();
        check("reset_mid_no_done", 32'(done_cnt - d0), 32'd0);
        run_layer(0, lat, err);
        check("after_reset_latency", 32'(lat), 32'(NN * P));

        for (int c = 0; c < 700; c++) begin
            start = ($urandom_range(0, 3) == 0);
            layer = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (NN * P + 4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
